// File: rtl/rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter_pkg
// Description : Shared types and constants for the ROM port arbiter:
//               FSM state encoding and requester port identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_arbiter_pkg;

    // Transaction sequencer states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Requester identifiers; also used as bit indices into the request vector
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage : rom_arbiter_pkg
`default_nettype wire

// File: rtl/rom_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin picker.
//               req[1:0] : request vector, indexed by port ID
//               last     : ID of the most recently granted port
//               grant_id : ID of the port to grant (valid when any = 1)
//               any      : at least one request is pending
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import rom_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_id,
    output logic       any
);

    always_comb begin
        any      = |req;
        grant_id = PORT_F;
        if (req[PORT_F] && req[PORT_D]) begin
            // Tie: the port that did not win last time goes first
            grant_id = ~last;
        end else if (req[PORT_D]) begin
            grant_id = PORT_D;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter
// Description : Shares the single ROM read port between the instruction-fetch
//               port (F) and the data-load port (D). Requests are serialised
//               with round-robin priority; each transaction takes four cycles
//               (IDLE, ISSUE, WAIT, ACK).
// Ports       : clk, reset (async, active-low)
//               f_req/f_addr/f_extra/f_lower/f_upper -> f_ack/f_data/f_error
//               d_req/d_addr/d_extra/d_lower/d_upper -> d_ack/d_data/d_error
//               mem_addr/mem_extra/mem_lower_bound/mem_upper_bound -> ROM
//               mem_data/mem_error <- ROM
//               busy : high whenever the sequencer is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int AW    = 5,
    parameter int EXTRA = 4,
    parameter int DW    = (2 ** EXTRA) * 8
) (
    input  logic             clk,
    input  logic             reset,
    // Fetch port
    input  logic             f_req,
    input  logic [AW:0]      f_addr,
    input  logic [EXTRA-1:0] f_extra,
    input  logic [AW:0]      f_lower,
    input  logic [AW:0]      f_upper,
    output logic             f_ack,
    output logic [DW-1:0]    f_data,
    output logic             f_error,
    // Data port
    input  logic             d_req,
    input  logic [AW:0]      d_addr,
    input  logic [EXTRA-1:0] d_extra,
    input  logic [AW:0]      d_lower,
    input  logic [AW:0]      d_upper,
    output logic             d_ack,
    output logic [DW-1:0]    d_data,
    output logic             d_error,
    // ROM side
    output logic [AW:0]      mem_addr,
    output logic [EXTRA-1:0] mem_extra,
    output logic [AW:0]      mem_lower_bound,
    output logic [AW:0]      mem_upper_bound,
    input  logic [DW-1:0]    mem_data,
    input  logic             mem_error,
    // Status
    output logic             busy
);

    state_t           r_state;
    logic             r_last;
    logic             r_grant;
    logic             r_busy;
    logic             r_f_ack;
    logic             r_d_ack;
    logic [DW-1:0]    r_f_data;
    logic [DW-1:0]    r_d_data;
    logic             r_f_error;
    logic             r_d_error;
    logic [AW:0]      r_mem_addr;
    logic [EXTRA-1:0] r_mem_extra;
    logic [AW:0]      r_mem_lower;
    logic [AW:0]      r_mem_upper;

    logic             w_grant_id;
    logic             w_any;
    logic [1:0]       w_req;

    assign w_req = {d_req, f_req};

    rr_pick2 u_pick (
        .req      (w_req),
        .last     (r_last),
        .grant_id (w_grant_id),
        .any      (w_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_last      <= PORT_D;      // F wins the first tie
            r_grant     <= PORT_F;
            r_busy      <= 1'b0;
            r_f_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_f_data    <= '0;
            r_d_data    <= '0;
            r_f_error   <= 1'b0;
            r_d_error   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_extra <= '0;
            r_mem_lower <= '0;
            r_mem_upper <= '1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_ISSUE;
                        r_busy  <= 1'b1;
                        r_grant <= w_grant_id;
                        r_last  <= w_grant_id;
                        if (w_grant_id == PORT_D) begin
                            r_mem_addr  <= d_addr;
                            r_mem_extra <= d_extra;
                            r_mem_lower <= d_lower;
                            r_mem_upper <= d_upper;
                        end else begin
                            r_mem_addr  <= f_addr;
                            r_mem_extra <= f_extra;
                            r_mem_lower <= f_lower;
                            r_mem_upper <= f_upper;
                        end
                    end
                end
                ST_ISSUE: begin
                    // ROM registers the address at the end of this cycle
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // ROM output is valid now; capture into the granted port
                    // only, zeroing the data on an error
                    r_state <= ST_ACK;
                    if (r_grant == PORT_D) begin
                        r_d_error <= mem_error;
                        r_d_data  <= mem_error ? '0 : mem_data;
                        r_d_ack   <= 1'b1;
                    end else begin
                        r_f_error <= mem_error;
                        r_f_data  <= mem_error ? '0 : mem_data;
                        r_f_ack   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_f_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign f_ack           = r_f_ack;
    assign f_data          = r_f_data;
    assign f_error         = r_f_error;
    assign d_ack           = r_d_ack;
    assign d_data          = r_d_data;
    assign d_error         = r_d_error;
    assign mem_addr        = r_mem_addr;
    assign mem_extra       = r_mem_extra;
    assign mem_lower_bound = r_mem_lower;
    assign mem_upper_bound = r_mem_upper;
    assign busy            = r_busy;

endmodule : rom_arbiter
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_arbiter
// Description : Self-checking bench for rom_arbiter. Directed stimulus pushes
//               expected responses (data, error, ack cycle) into per-port
//               queues; a monitor pops and compares on every ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

    localparam int AW    = 5;
    localparam int EXTRA = 4;
    localparam int DW    = 128;

    logic             clk;
    logic             reset;
    logic             f_req, d_req;
    logic [AW:0]      f_addr, f_lower, f_upper, d_addr, d_lower, d_upper;
    logic [EXTRA-1:0] f_extra, d_extra;
    logic             f_ack, d_ack, f_error, d_error, busy, mem_error;
    logic [DW-1:0]    f_data, d_data, mem_data;
    logic [AW:0]      mem_addr, mem_lower_bound, mem_upper_bound;
    logic [EXTRA-1:0] mem_extra;

    rom_arbiter #(.AW(AW), .EXTRA(EXTRA)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_extra(f_extra), .f_lower(f_lower),
        .f_upper(f_upper), .f_ack(f_ack), .f_data(f_data), .f_error(f_error),
        .d_req(d_req), .d_addr(d_addr), .d_extra(d_extra), .d_lower(d_lower),
        .d_upper(d_upper), .d_ack(d_ack), .d_data(d_data), .d_error(d_error),
        .mem_addr(mem_addr), .mem_extra(mem_extra),
        .mem_lower_bound(mem_lower_bound), .mem_upper_bound(mem_upper_bound),
        .mem_data(mem_data), .mem_error(mem_error), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: byte i = 0x41 + i; registered one cycle after the address.
    // Data is returned even on a bound error so the arbiter's zeroing shows.
    logic [7:0] rom [64];
    initial for (int i = 0; i < 64; i++) rom[i] = 8'h41 + 8'(i);

    always @(posedge clk) begin
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (i <= int'(mem_extra)) r[i*8 +: 8] = rom[(int'(mem_addr) + i) % 64];
        mem_data  <= r;
        mem_error <= (int'(mem_addr) < int'(mem_lower_bound)) ||
                     (int'(mem_addr) + int'(mem_extra) > int'(mem_upper_bound));
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            ack_cyc;
    } exp_t;

    exp_t qf[$];
    exp_t qd[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] d, input logic e, input int c);
        exp_t x;
        x.data = d; x.err = e; x.ack_cyc = c;
        return x;
    endfunction

    // Monitor: compares every ack against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (qf.size() > 0 && qf[0].ack_cyc < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL f_missing_ack: no ack observed, expected at cycle %0d", qf[0].ack_cyc);
            void'(qf.pop_front());
        end
        if (qd.size() > 0 && qd[0].ack_cyc < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL d_missing_ack: no ack observed, expected at cycle %0d", qd[0].ack_cyc);
            void'(qd.pop_front());
        end
        if (f_ack === 1'b1) begin
            if (qf.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL f_unexpected_ack: got ack at cycle %0d, expected none", cyc);
            end else begin
                e = qf.pop_front();
                chk("f_ack_cycle", DW'(cyc), DW'(e.ack_cyc));
                chk("f_data", f_data, e.data);
                chk("f_error", DW'(f_error), DW'(e.err));
            end
        end
        if (d_ack === 1'b1) begin
            if (qd.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL d_unexpected_ack: got ack at cycle %0d, expected none", cyc);
            end else begin
                e = qd.pop_front();
                chk("d_ack_cycle", DW'(cyc), DW'(e.ack_cyc));
                chk("d_data", d_data, e.data);
                chk("d_error", DW'(d_error), DW'(e.err));
            end
        end
    end

    initial begin
        int c;
        reset = 1'b0;
        f_req = 0; d_req = 0;
        f_addr = 0; f_extra = 0; f_lower = 0; f_upper = 6'd63;
        d_addr = 0; d_extra = 0; d_lower = 0; d_upper = 6'd63;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_acks", DW'({f_ack, d_ack}), '0);
        chk("rst_mem_addr", DW'(mem_addr), '0);
        chk("rst_mem_upper", DW'(mem_upper_bound), DW'(6'h3F));
        chk("rst_f_data", f_data, '0);
        reset = 1'b1;
        @(negedge clk);

        // ---------------- simultaneous requests out of reset ----------------
        c = cyc;
        f_addr = 6'd4;  f_extra = 4'd3;
        d_addr = 6'd12; d_extra = 4'd0;
        f_req = 1; d_req = 1;
        qf.push_back(mk(128'h48474645, 1'b0, c + 3));
        qd.push_back(mk(128'h4D, 1'b0, c + 7));
        @(negedge clk);
        chk("sim_mem_addr_f", DW'(mem_addr), DW'(6'd4));
        chk("sim_busy_issue", DW'(busy), DW'(1'b1));
        repeat (2) @(negedge clk);
        f_req = 0;
        repeat (2) @(negedge clk);
        chk("sim_mem_addr_d", DW'(mem_addr), DW'(6'd12));
        repeat (2) @(negedge clk);
        d_req = 0;
        @(negedge clk);

        // ---------------- starvation: both held 16 cycles ----------------
        c = cyc;
        f_addr = 6'd8;  f_extra = 4'd0;
        d_addr = 6'd20; d_extra = 4'd1;
        f_req = 1; d_req = 1;
        qf.push_back(mk(128'h49, 1'b0, c + 3));
        qd.push_back(mk(128'h5655, 1'b0, c + 7));
        qf.push_back(mk(128'h49, 1'b0, c + 11));
        qd.push_back(mk(128'h5655, 1'b0, c + 15));
        repeat (15) @(negedge clk);
        f_req = 0; d_req = 0;
        @(negedge clk);

        // ---------------- single fetch ----------------
        c = cyc;
        f_addr = 6'd0; f_extra = 4'd0;
        f_req = 1;
        qf.push_back(mk(128'h41, 1'b0, c + 3));
        repeat (3) @(negedge clk);
        f_req = 0;
        @(negedge clk);

        // ---------------- bound error on D ----------------
        c = cyc;
        d_addr = 6'd10; d_extra = 4'd0; d_lower = 6'd0; d_upper = 6'd8;
        d_req = 1;
        qd.push_back(mk('0, 1'b1, c + 3));
        repeat (3) @(negedge clk);
        d_req = 0;
        @(negedge clk);
        chk("err_f_data_held", f_data, 128'h41);
        d_upper = 6'd63;

        // ---------------- held request across ACK ----------------
        c = cyc;
        f_addr = 6'd0; f_extra = 4'd0;
        f_req = 1;
        qf.push_back(mk(128'h41, 1'b0, c + 3));
        qf.push_back(mk(128'h51, 1'b0, c + 7));
        repeat (4) @(negedge clk);
        f_addr = 6'd16;
        repeat (3) @(negedge clk);
        f_req = 0;
        @(negedge clk);

        // ---------------- reset mid-transaction ----------------
        f_addr = 6'd2; f_extra = 4'd1;
        f_req = 1;
        repeat (2) @(negedge clk);
        chk("rst_pre_busy", DW'(busy), DW'(1'b1));
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", DW'(busy), '0);
        chk("mid_rst_f_ack", DW'(f_ack), '0);
        chk("mid_rst_f_data", f_data, '0);
        chk("mid_rst_mem_addr", DW'(mem_addr), '0);
        chk("mid_rst_mem_upper", DW'(mem_upper_bound), DW'(6'h3F));
        @(negedge clk);
        reset = 1'b1;
        qf.push_back(mk(128'h4443, 1'b0, cyc + 3));
        repeat (3) @(negedge clk);
        f_req = 0;
        repeat (2) @(negedge clk);

        chk("sb_f_empty", DW'(qf.size()), '0);
        chk("sb_d_empty", DW'(qd.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_rom_arbiter
`default_nettype wire

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single `genrom` read port between the CPU instruction-fetch path (port F) and the data-load path (port D). It sits between `cpu` and `genrom`. It serialises requests with round-robin priority, drives the ROM address, extra-byte count and bound registers for the granted requester, and returns the ROM data and error flag to that requester with a one-cycle `ack`.

## Interface
- `AW`, default 5: ROM address depth; addresses are `AW+1` bits wide.
- `EXTRA`, default 4: width of the extra-byte count; data width `DW = 2**EXTRA*8` (128 at default).
- `clk` input, 1: system clock; everything is on the rising edge.
- `reset` input, 1: asynchronous, active-low (0 = reset).
- `f_req` input, 1: fetch request; held high with stable request fields until `f_ack`.
- `f_addr` input, AW+1: fetch byte address.
- `f_extra` input, EXTRA: fetch extra-byte count.
- `f_lower`, `f_upper` inputs, AW+1 each: fetch bounds (code section).
- `f_ack` output, 1: one-cycle completion pulse.
- `f_data` output, DW: fetch read data; valid with `f_ack` and held until the next `f_ack`.
- `f_error` output, 1: bound or ROM error; valid with `f_ack`.
- `d_req`, `d_addr`, `d_extra`, `d_lower`, `d_upper`, `d_ack`, `d_data`, `d_error`: the same set for the data port.
- `mem_addr` output, AW+1: to `genrom` `addr`.
- `mem_extra` output, EXTRA: to `genrom` `extra`.
- `mem_lower_bound`, `mem_upper_bound` outputs, AW+1: to `genrom` bounds.
- `mem_data` input, DW: from `genrom`.
- `mem_error` input, 1: from `genrom`.
- `busy` output, 1: high in every state other than IDLE.

## Operation
- FSM states:
  - IDLE: sample requests.
  - ISSUE: ROM samples the address at the end of this cycle.
  - WAIT: `mem_data`/`mem_error` are valid; they are captured into the response register at the end of this cycle.
  - ACK: the granted port's `ack` is 1.
- Transitions:
  - IDLE→ISSUE when any `req` is high.
  - ISSUE→WAIT unconditionally.
  - WAIT→ACK unconditionally.
  - ACK→IDLE unconditionally.
- Grant, decided in IDLE:
  - A single requester is granted.
  - If both are requesting, grant goes to the port that is not `last_grant`.
  - `last_grant` updates on entry to ISSUE.
  - Reset value of `last_grant` = D, so F wins the first tie.
- On IDLE→ISSUE, the granted port's `addr`/`extra`/`lower`/`upper` are registered into the `mem_*` outputs. The `mem_*` outputs hold their value in every other state.
- Response capture at end of WAIT:
  - `x_error <= mem_error`.
  - `x_data <= mem_error ? 0 : mem_data`.
  - Only the granted port's data/error registers are written; the other port's registers are untouched.
- Requester rules:
  - Request fields must stay stable from `req` rising until `ack`.
  - `req` may stay high in the ACK cycle and is treated as a new request in the following IDLE.
  - A request change before `ack` is a protocol violation; the resulting behaviour is undefined.
- Fairness: a port that keeps requesting waits at most one foreign transaction (4 cycles) before being granted.
- Reset (asynchronous, any state):
  - FSM→IDLE.
  - `f_ack = d_ack = busy = 0`.
  - `f_data = d_data = 0`, `f_error = d_error = 0`.
  - `mem_addr = mem_extra = mem_lower_bound = 0`, `mem_upper_bound = all-ones`.
  - An in-flight transaction is dropped without an `ack`; the requester re-issues after reset.

## Timing
- Latency: `req` high at edge N (IDLE) → ISSUE in cycle N+1 → WAIT in N+2 → `ack` high during N+3, for exactly one cycle.
- Throughput: one transaction per 4 cycles; back-to-back requests from alternating ports are granted in consecutive IDLE windows.
- All outputs are registered; there is no combinational path from `req` to any output.
- `busy` = (state != IDLE).

## Structure
- Package `rom_arbiter_pkg`:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, ACK=3);
  - port-ID constants `PORT_F=0`, `PORT_D=1`.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `grant_id`, `any`.
  - Instantiated once.
- Width parameters are passed in from the `cpu`-level `MEM_DEPTH`; the ROM interface is unchanged.

## Test plan
- Single fetch:
  - Stimulus: ROM byte 0 = 0x41; `f_req`, `f_addr=0`, `f_extra=0`, bounds 0..63.
  - Required: `f_ack` exactly 3 cycles after the sampling edge; `f_data[7:0]=0x41`; `f_error=0`; `d_ack` stays 0.
- Simultaneous requests out of reset:
  - Stimulus: `f_req` and `d_req` both high.
  - Required: F acked at cycle 3 and D at cycle 7; `mem_addr` switches to `d_addr` in D's ISSUE cycle.
- Starvation:
  - Stimulus: both `req` held high for 16 cycles.
  - Required: acks alternate F, D, F, D; no port gets two consecutive grants.
- Bound error:
  - Stimulus: `d_addr=10` with `d_lower=0`, `d_upper=8`.
  - Required: `d_error=1` and `d_data=0` with `d_ack`; the previously held `f_data` is unchanged.
- Reset mid-transaction:
  - Stimulus: reset asserted in the WAIT cycle of an F transaction, then released, with `f_req` still high.
  - Required: no `f_ack` during reset and all outputs at their reset values; a fresh transaction completes 3 cycles after the first IDLE edge following release.
- Held request across ACK:
  - Stimulus: `f_req` kept high through ACK with `f_addr` changed to 16 the cycle after ACK.
  - Required: a second transaction reads address 16, and `f_ack` arrives 4 cycles after the first.
